// File: rtl/jt51_timer_regs.sv
// CPU register front end for the timer pair: decodes address/data port writes into timer
// controls, returns the status byte and forwards all other register writes upstream.
module jt51_timer_regs #(
    parameter int unsigned BUSY_CYCLES = 32
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       overflow_A,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       csm,
    output logic       csm_kon,
    output logic [7:0] up_addr,
    output logic [7:0] up_data,
    output logic       up_wr
);

    localparam int unsigned CW = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES);

    logic          wr_act;
    logic          wr_act_q;
    logic          wr_evt;
    logic          data_wr;
    logic          busy;
    logic [CW-1:0] busy_cnt_q;
    logic [7:0]    addr_q;

    // One event per strobe assertion, however long the CPU holds it
    assign wr_act  = !cs_n && !wr_n;
    assign wr_evt  = wr_act && !wr_act_q;
    assign busy    = (busy_cnt_q != '0);
    assign data_wr = wr_evt && a0 && !busy;
    assign dout    = {busy, 5'b0, flag_B, flag_A};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_act_q   <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            wr_act_q <= wr_act;
            // A fresh load wins over a same-edge countdown tick
            if (data_wr) begin
                busy_cnt_q <= BUSY_LOAD;
            end else if (cen && busy) begin
                busy_cnt_q <= busy_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= 8'd0;
            value_A      <= 10'd0;
            value_B      <= 8'd0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
            csm          <= 1'b0;
            csm_kon      <= 1'b0;
            up_addr      <= 8'd0;
            up_data      <= 8'd0;
            up_wr        <= 1'b0;
        end else begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            up_wr      <= 1'b0;
            csm_kon    <= overflow_A && csm;
            if (wr_evt && !a0) begin
                addr_q <= din;
            end
            if (data_wr) begin
                case (addr_q)
                    8'h10: value_A[9:2] <= din;
                    8'h11: value_A[1:0] <= din[1:0];
                    8'h12: value_B      <= din;
                    8'h13: ;  // inside the timer block: swallowed, never forwarded
                    8'h14: begin
                        csm          <= din[7];
                        clr_flag_B   <= din[5];
                        clr_flag_A   <= din[4];
                        enable_irq_B <= din[3];
                        enable_irq_A <= din[2];
                        load_B       <= din[1];
                        load_A       <= din[0];
                    end
                    default: begin
                        up_addr <= addr_q;
                        up_data <= din;
                        up_wr   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
